// File: rtl/pong_pkg.sv
// Shared definitions for the pong game sequencer.
// State encoding, velocity thresholds and the score-to-speed mapping.
package pong_pkg;

    localparam int CNT_W = 7;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SERVE  = 3'd1;
    localparam logic [2:0] ST_PLAY   = 3'd2;
    localparam logic [2:0] ST_PAUSED = 3'd3;
    localparam logic [2:0] ST_MISS   = 3'd4;
    localparam logic [2:0] ST_OVER   = 3'd5;

    localparam logic [7:0] VEL_T1 = 8'd10;
    localparam logic [7:0] VEL_T2 = 8'd20;
    localparam logic [7:0] VEL_T3 = 8'd26;

    localparam logic [3:0] VEL_MIN = 4'd1;
    localparam logic [3:0] VEL_MAX = 4'd4;

    function automatic logic [3:0] vel_of(input logic [7:0] s);
        logic [3:0] v;
        v = VEL_MAX;
        if (s < VEL_T1) begin
            v = VEL_MIN;
        end else if (s < VEL_T2) begin
            v = 4'd2;
        end else if (s < VEL_T3) begin
            v = 4'd3;
        end
        return v;
    endfunction

endpackage

// File: rtl/pong_speed_lut.sv
// Registered score-to-velocity lookup.
// Velocity follows the score one clock later.
module pong_speed_lut
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       Reset,
    input  logic [7:0] score_i,
    output logic [3:0] vel_o
);

    logic [3:0] vel_q;
    logic [3:0] vel_d;

    assign vel_d = vel_of(score_i);
    assign vel_o = vel_q;

    always_ff @(posedge clk) begin
        if (Reset) begin
            vel_q <= VEL_MIN;
        end else begin
            vel_q <= vel_d;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve, play, miss recovery, pause and game over.
// Consumes per-frame events and drives the ball enables, score and lives.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 30,
    parameter int WIN_SCORE    = 33
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       start_pulse,
    input  logic       pause_pulse,
    input  logic       paddle_hit,
    input  logic       ball_miss,
    output logic       ball_run,
    output logic       ball_reload,
    output logic [3:0] velocity,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over,
    output logic       win
);

    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] MISS_LAST  = CNT_W'(MISS_FRAMES - 1);
    localparam logic [7:0]       WIN_VAL    = 8'(WIN_SCORE);
    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       score_q, score_d;
    logic [1:0]       lives_q, lives_d;
    logic             win_q, win_d;
    logic [7:0]       score_inc;

    assign score_inc = score_q + 8'd1;

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        win_d   = win_q;
        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_pulse) begin
                    state_d = ST_SERVE;
                    score_d = 8'd0;
                    lives_d = LIVES_INIT;
                    win_d   = 1'b0;
                end
            end
            ST_SERVE: begin
                if (frame_tick && cnt_q == SERVE_LAST) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // A frame event wins over a simultaneous pause press.
                if (frame_tick && paddle_hit) begin
                    score_d = score_inc;
                    if (score_inc == WIN_VAL) begin
                        state_d = ST_OVER;
                        win_d   = 1'b1;
                    end
                end else if (frame_tick && ball_miss) begin
                    if (lives_q == 2'd1) begin
                        lives_d = 2'd0;
                        state_d = ST_OVER;
                        win_d   = 1'b0;
                    end else begin
                        lives_d = lives_q - 2'd1;
                        state_d = ST_MISS;
                    end
                end else if (pause_pulse) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (start_pulse) begin
                    state_d = ST_SERVE;
                    score_d = 8'd0;
                    lives_d = LIVES_INIT;
                    win_d   = 1'b0;
                end else if (pause_pulse) begin
                    state_d = ST_PLAY;
                end
            end
            ST_MISS: begin
                if (frame_tick && cnt_q == MISS_LAST) begin
                    state_d = ST_SERVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (frame_tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            score_q <= 8'd0;
            lives_q <= LIVES_INIT;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            lives_q <= lives_d;
            win_q   <= win_d;
        end
    end

    pong_speed_lut u_speed (
        .clk     (clk),
        .Reset   (Reset),
        .score_i (score_q),
        .vel_o   (velocity)
    );

    assign ball_run    = (state_q == ST_PLAY);
    assign ball_reload = (state_q == ST_IDLE) || (state_q == ST_SERVE) ||
                         (state_q == ST_OVER);
    assign game_over   = (state_q == ST_OVER);
    assign score       = score_q;
    assign lives       = lives_q;
    assign win         = win_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl.
// Table-driven PLAY/PAUSE vectors plus directed multi-frame sequences.
module tb_pong_game_ctrl;
    import pong_pkg::*;

    logic       clk = 1'b0;
    logic       Reset;
    logic       frame_tick, start_pulse, pause_pulse, paddle_hit, ball_miss;
    logic       ball_run, ball_reload, game_over, win;
    logic [3:0] velocity;
    logic [7:0] score;
    logic [1:0] lives;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       ft, st, pa, hit, miss;
        logic [7:0] score;
        logic [1:0] lives;
        logic       run, reload, go, win;
    } vec_t;

    vec_t tbl[10];

    pong_game_ctrl dut (
        .clk         (clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .start_pulse (start_pulse),
        .pause_pulse (pause_pulse),
        .paddle_hit  (paddle_hit),
        .ball_miss   (ball_miss),
        .ball_run    (ball_run),
        .ball_reload (ball_reload),
        .velocity    (velocity),
        .score       (score),
        .lives       (lives),
        .game_over   (game_over),
        .win         (win)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic ft, st, pa, hit, miss,
        input int sc, lv,
        input logic run, rl, go, w);
        vec_t v;
        v.ft = ft; v.st = st; v.pa = pa; v.hit = hit; v.miss = miss;
        v.score = 8'(sc); v.lives = 2'(lv);
        v.run = run; v.reload = rl; v.go = go; v.win = w;
        return v;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int sc, input int lv,
                           input int run, input int rl, input int go,
                           input int w);
        chk({nm, ".score"}, int'(score), sc);
        chk({nm, ".lives"}, int'(lives), lv);
        chk({nm, ".run"}, int'(ball_run), run);
        chk({nm, ".reload"}, int'(ball_reload), rl);
        chk({nm, ".game_over"}, int'(game_over), go);
        chk({nm, ".win"}, int'(win), w);
    endtask

    task automatic cyc(input logic ft, st, pa, hit, miss);
        frame_tick  = ft;
        start_pulse = st;
        pause_pulse = pa;
        paddle_hit  = hit;
        ball_miss   = miss;
        @(negedge clk);
        frame_tick  = 1'b0;
        start_pulse = 1'b0;
        pause_pulse = 1'b0;
        paddle_hit  = 1'b0;
        ball_miss   = 1'b0;
    endtask

    task automatic ticks(input int n, input logic hit, input logic miss);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, hit, miss);
    endtask

    // From SERVE entry: 59 ticks still serving, the 60th enters PLAY.
    task automatic serve_to_play(input string nm, input bit poke_start);
        ticks(30, 1'b0, 1'b0);
        if (poke_start) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(29, 1'b0, 1'b0);
        chk({nm, ".serve59.reload"}, int'(ball_reload), 1);
        chk({nm, ".serve59.run"}, int'(ball_run), 0);
        ticks(1, 1'b0, 1'b0);
        chk({nm, ".serve60.run"}, int'(ball_run), 1);
        chk({nm, ".serve60.reload"}, int'(ball_reload), 0);
    endtask

    // From MISS entry: 29 ticks frozen, the 30th returns to SERVE.
    task automatic miss_to_play(input string nm);
        ticks(29, 1'b0, 1'b0);
        chk({nm, ".miss29.reload"}, int'(ball_reload), 0);
        chk({nm, ".miss29.run"}, int'(ball_run), 0);
        ticks(1, 1'b0, 1'b0);
        chk({nm, ".miss30.reload"}, int'(ball_reload), 1);
        serve_to_play(nm, 1'b0);
    endtask

    initial begin
        tbl[0] = mk(1, 0, 0, 1, 0, 1, 3, 1, 0, 0, 0);
        tbl[1] = mk(0, 0, 0, 1, 0, 1, 3, 1, 0, 0, 0);
        tbl[2] = mk(1, 0, 0, 1, 1, 2, 3, 1, 0, 0, 0);
        tbl[3] = mk(1, 0, 1, 1, 0, 3, 3, 1, 0, 0, 0);
        tbl[4] = mk(1, 0, 0, 0, 0, 3, 3, 1, 0, 0, 0);
        tbl[5] = mk(0, 0, 1, 0, 0, 3, 3, 0, 0, 0, 0);
        tbl[6] = mk(1, 0, 0, 1, 0, 3, 3, 0, 0, 0, 0);
        tbl[7] = mk(1, 0, 0, 0, 1, 3, 3, 0, 0, 0, 0);
        tbl[8] = mk(0, 0, 1, 0, 0, 3, 3, 1, 0, 0, 0);
        tbl[9] = mk(0, 0, 0, 0, 1, 3, 3, 1, 0, 0, 0);

        Reset = 1'b1;
        frame_tick = 0; start_pulse = 0; pause_pulse = 0;
        paddle_hit = 0; ball_miss = 0;
        @(negedge clk);
        @(negedge clk);
        chk_all("reset", 0, 3, 0, 1, 0, 0);
        chk("reset.vel", int'(velocity), 1);
        Reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("idle_tick", 0, 3, 0, 1, 0, 0);

        // Start, serve for exactly 60 ticks; a start press mid-serve is ignored
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("serve", 0, 3, 0, 1, 0, 0);
        serve_to_play("t1", 1'b1);
        chk_all("play", 0, 3, 1, 0, 0, 0);
        chk("play.vel", int'(velocity), 1);

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].ft, tbl[i].st, tbl[i].pa, tbl[i].hit, tbl[i].miss);
            chk_all($sformatf("vec%0d", i), int'(tbl[i].score),
                    int'(tbl[i].lives), int'(tbl[i].run),
                    int'(tbl[i].reload), int'(tbl[i].go), int'(tbl[i].win));
        end

        // Velocity thresholds, lagging score by one clock
        ticks(6, 1'b1, 1'b0);
        chk("s9.vel", int'(velocity), 1);
        ticks(1, 1'b1, 1'b0);
        chk("s10.score", int'(score), 10);
        chk("s10.vel_lag", int'(velocity), 1);
        cyc(0, 0, 0, 0, 0);
        chk("s10.vel", int'(velocity), 2);
        ticks(10, 1'b1, 1'b0);
        chk("s20.score", int'(score), 20);
        chk("s20.vel_lag", int'(velocity), 2);
        cyc(0, 0, 0, 0, 0);
        chk("s20.vel", int'(velocity), 3);
        ticks(6, 1'b1, 1'b0);
        chk("s26.vel_lag", int'(velocity), 3);
        cyc(0, 0, 0, 0, 0);
        chk_all("s26", 26, 3, 1, 0, 0, 0);
        chk("s26.vel", int'(velocity), 4);

        // Miss: freeze, re-serve, play
        ticks(1, 1'b0, 1'b1);
        chk_all("miss1", 26, 2, 0, 0, 0, 0);
        miss_to_play("t3a");
        chk_all("replay", 26, 2, 1, 0, 0, 0);

        // Win path, with simultaneous hit+miss on the way
        ticks(5, 1'b1, 1'b0);
        ticks(1, 1'b1, 1'b1);
        chk_all("hitmiss", 32, 2, 1, 0, 0, 0);
        ticks(1, 1'b1, 1'b0);
        chk_all("win", 33, 2, 0, 1, 1, 1);
        ticks(3, 1'b1, 1'b1);
        chk_all("win_frozen", 33, 2, 0, 1, 1, 1);
        chk("win.vel", int'(velocity), 4);
        cyc(0, 1, 0, 0, 0);
        chk_all("restart", 0, 3, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("restart.vel", int'(velocity), 1);

        // Lose all lives
        serve_to_play("t3b", 1'b0);
        ticks(2, 1'b1, 1'b0);
        ticks(1, 1'b0, 1'b1);
        chk("lose1.lives", int'(lives), 2);
        miss_to_play("t3c");
        ticks(1, 1'b0, 1'b1);
        chk("lose2.lives", int'(lives), 1);
        miss_to_play("t3d");
        ticks(1, 1'b0, 1'b1);
        chk_all("lose", 2, 0, 0, 1, 1, 0);
        ticks(2, 1'b1, 1'b1);
        chk_all("lose_frozen", 2, 0, 0, 1, 1, 0);

        // Pause, ignored hits, resume, restart from pause
        cyc(0, 1, 0, 0, 0);
        serve_to_play("t5", 1'b0);
        ticks(1, 1'b1, 1'b0);
        cyc(0, 0, 1, 0, 0);
        chk_all("paused", 1, 3, 0, 0, 0, 0);
        ticks(5, 1'b1, 1'b0);
        chk_all("paused_hits", 1, 3, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk_all("resumed", 1, 3, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk_all("pause_restart", 0, 3, 0, 1, 0, 0);

        // Reset mid-MISS overrides simultaneous inputs
        serve_to_play("t6", 1'b0);
        ticks(1, 1'b1, 1'b0);
        ticks(1, 1'b0, 1'b1);
        ticks(15, 1'b0, 1'b0);
        chk("midmiss.cnt", int'(dut.cnt_q), 15);
        chk_all("midmiss", 1, 2, 0, 0, 0, 0);
        Reset = 1'b1;
        cyc(1, 1, 1, 1, 1);
        chk_all("rst_mid", 0, 3, 0, 1, 0, 0);
        chk("rst_mid.cnt", int'(dut.cnt_q), 0);
        chk("rst_mid.state", int'(dut.state_q), int'(ST_IDLE));
        chk("rst_mid.vel", int'(velocity), 1);
        Reset = 1'b0;
        cyc(0, 0, 0, 0, 0);
        chk_all("post_rst", 0, 3, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game sequencer for the pong datapath. It consumes one-per-frame collision and miss events and steps the game through idle, serve, play, miss-recovery, pause and game-over. It drives the ball move-enable and reload strobes, the ball speed level, the score shown on the LEDs, and the remaining lives. It sits between the debounced buttons and collision detectors on one side and the ball-position update logic on the other.

Parameters:
LIVES, 3, lives granted at game start (1..3)
SERVE_FRAMES, 60, frame ticks the ball is held at the serve position before play
MISS_FRAMES, 30, frame ticks of freeze after a miss
WIN_SCORE, 33, score value that ends the game as a win (2..255)

Ports:
clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame; the same strobe as the ball position update
start_pulse  in  1  one-cycle debounced start/restart press
pause_pulse  in  1  one-cycle debounced pause toggle
paddle_hit  in  1  paddle collision latched for the current frame; valid when frame_tick=1
ball_miss  in  1  ball reached the bottom border this frame; valid when frame_tick=1
ball_run  out  1  ball may move on this frame_tick
ball_reload  out  1  load the serve position (level, held)
velocity  out  4  ball step in pixels per frame, 1..4
score  out  8  paddle hits this game; drives the LEDs
lives  out  2  remaining lives
game_over  out  1  high in the GAME_OVER state
win  out  1  valid while game_over=1; 1 = WIN_SCORE reached, 0 = lives exhausted

Behaviour:
- All state is registered. Every input is sampled on the rising edge of clk.
- Reset state and outputs:
  - state=IDLE, score=0, lives=LIVES, velocity=1
  - ball_run=0, ball_reload=1, game_over=0, win=0
  - frame counter=0
- Frame counter: 7 bits. It is cleared on every state entry and increments only on frame_tick.
- IDLE:
  - Outputs: ball_reload=1, ball_run=0.
  - start_pulse: score<=0, lives<=LIVES, win<=0, go to SERVE.
- SERVE:
  - Outputs: ball_reload=1, ball_run=0.
  - On the frame_tick where counter==SERVE_FRAMES-1, go to PLAY.
- PLAY:
  - Outputs: ball_reload=0, ball_run=1.
  - Events are acted on only when frame_tick=1.
  - paddle_hit=1:
    - score<=score+1.
    - If score+1==WIN_SCORE: go to GAME_OVER with win<=1.
    - Hit takes priority: ball_miss in the same tick is ignored.
  - ball_miss=1 and paddle_hit=0:
    - If lives==1: lives<=0, go to GAME_OVER with win<=0.
    - Otherwise: lives<=lives-1, go to MISS.
  - pause_pulse (no frame_tick required): go to PAUSED. If a pause_pulse and a frame_tick event arrive in the same cycle, the event is processed and the pause is dropped.
- PAUSED:
  - Outputs: ball_run=0, ball_reload=0.
  - frame_tick events are ignored.
  - pause_pulse: return to PLAY.
  - start_pulse: restart as from IDLE.
- MISS:
  - Outputs: ball_run=0, ball_reload=0.
  - On the frame_tick where counter==MISS_FRAMES-1, go to SERVE.
- GAME_OVER:
  - Outputs: ball_run=0, ball_reload=1, game_over=1.
  - score, lives and win are frozen.
  - start_pulse: restart as from IDLE, going directly to SERVE.
- start_pulse in SERVE or MISS is ignored.
- Velocity is registered and updates one cycle after score changes:
  - score<10 -> 1
  - score<20 -> 2
  - score<26 -> 3
  - otherwise -> 4
- Score never wraps, because the game ends at WIN_SCORE. lives never underflows.
- Reset asserted in any state, including mid-count, takes effect on the next edge and overrides every other input.

Decomposition:
- Shared package pong_pkg holds:
  - state encoding: IDLE, SERVE, PLAY, PAUSED, MISS, GAME_OVER (3 bits)
  - velocity thresholds 10/20/26 and VEL_MIN=1, VEL_MAX=4
  - frame counter width
- One natural sub-module: pong_speed_lut (score -> velocity, registered).
- The FSM, counter and score/lives registers stay in pong_game_ctrl.

Test Plan:
1. Reset, then start_pulse -> SERVE with ball_reload=1. After exactly 60 frame_ticks -> PLAY with ball_run=1, score=0, lives=3, velocity=1.
2. In PLAY, 10 ticks with paddle_hit=1 -> score=10. velocity=2 one cycle after score reaches 10. A further 10 hits -> velocity=3 at 20. At 26 -> velocity=4.
3. In PLAY, a tick with ball_miss=1 -> lives=2, MISS for 30 ticks, then SERVE for 60 ticks, then PLAY. Third miss -> lives=0, game_over=1, win=0, score held.
4. Tick with paddle_hit=1 and ball_miss=1 together -> score+1, lives unchanged. At score=32 a hit -> score=33, game_over=1, win=1.
5. pause_pulse in PLAY -> ball_run=0. Five ticks with paddle_hit=1 -> score unchanged. pause_pulse again -> PLAY. start_pulse in GAME_OVER -> score=0, lives=3, SERVE.
6. Reset asserted in the middle of MISS (counter=15) -> IDLE next cycle, all outputs at their reset values, counter=0.
